// File: rtl/if_fetch_queue_pkg.sv
// Shared types and default constants for the instruction-fetch queue.
package if_fetch_queue_pkg;

   // addi x0,x0,0
   localparam logic [31:0] InstNop        = 32'h0000_0013;
   localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with push, pop and a flush-style clear.
// The pointers carry one extra MSB so full and empty can be told apart.
module if_fetch_queue_fetch_fifo
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  fq_entry_t                wdata_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output fq_entry_t                head_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   fq_entry_t   mem_q [DEPTH];
   logic        full, empty;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer next-state: clear wins over push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i && !full) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_i && !full && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues sequential imem fetches under a credit limit,
// buffers returned words with their PCs and presents one instruction per cycle to IF/ID.
// Redirects flush the buffer and mark in-flight fetches for discard.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = ResetPcDefault,
   parameter logic [31:0] NOP_INST = InstNop
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam int unsigned CW = $clog2(MAX_OUT * 2 + 1);
   localparam int unsigned NW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] disc_q, disc_d;

   logic [NW-1:0] fifo_count;
   fq_entry_t     fifo_head;
   fq_entry_t     fifo_wdata;
   logic          gnt_fire, rsp_live, rsp_drop;
   logic          fifo_push, fifo_pop;
   logic [31:0]   redirect_word;
   logic          unused_redirect_lsb;

   assign redirect_word       = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Credit check keeps a FIFO slot reserved for every live in-flight response.
   always_comb begin
      imem_req = rst && !redirect_valid
                 && (32'(out_q) < MAX_OUT)
                 && ((32'(fifo_count) + 32'(out_q)) < DEPTH);
      gnt_fire = imem_req && imem_gnt;
      rsp_drop = imem_rvalid && (disc_q != '0);
      rsp_live = imem_rvalid && (disc_q == '0);
      fifo_push = rsp_live && !redirect_valid;
      fifo_pop  = inst_valid && !stall && !redirect_valid;
   end

   assign fifo_wdata = '{pc: resp_pc_q, inst: imem_rdata};

   // Next-state for PCs and counters; redirect folds surviving requests into discard.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      out_d      = out_q;
      disc_d     = disc_q;
      if (gnt_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         out_d      = out_d + CW'(1);
      end
      if (rsp_drop) disc_d = disc_q - CW'(1);
      if (rsp_live) begin
         resp_pc_d = resp_pc_q + 32'd4;
         out_d     = out_d - CW'(1);
      end
      if (redirect_valid) begin
         fetch_pc_d = redirect_word;
         resp_pc_d  = redirect_word;
         disc_d     = disc_d + out_d;
         out_d      = '0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         disc_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
      end
   end

   if_fetch_queue_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .clear_i (redirect_valid),
      .wdata_i (fifo_wdata),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   // Outputs: head entry shown directly, NOP and zero PC when empty.
   always_comb begin
      imem_addr  = fetch_pc_q;
      inst_valid = (fifo_count != '0);
      inst_out   = inst_valid ? fifo_head.inst : NOP_INST;
      pc_out     = inst_valid ? fifo_head.pc : 32'h0;
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a simple in-order imem responder.
module tb_if_fetch_queue;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] pc_out;

   int          vectors;
   int          miscompares;
   logic        hold;
   logic [31:0] rq [$];

   localparam logic [31:0] Nop = 32'h0000_0013;

   if_fetch_queue dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_out       (inst_out),
      .pc_out         (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: record handshakes mid-cycle, then present the oldest pending response
   // in the following cycle unless responses are being held back.
   task automatic cycle();
      @(negedge clk);
      if (imem_req && imem_gnt) rq.push_back(imem_addr);
      @(posedge clk);
      #1;
      if (!hold && rq.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = inst_of(rq.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      hold           = 1'b0;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      stall          = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;

      // Reset values.
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst_out, Nop);
      chk("rst_pc", pc_out, 32'h0);
      cycle();
      cycle();

      // Streaming: first instruction two edges after release, then one per cycle.
      rst      = 1'b1;
      imem_gnt = 1'b1;
      cycle();
      chk("fill_valid", 32'(inst_valid), 32'd0);
      cycle();
      chk("s_valid", 32'(inst_valid), 32'd1);
      chk("s_pc0", pc_out, 32'h0);
      chk("s_inst0", inst_out, inst_of(32'h0));
      for (int i = 1; i <= 5; i++) begin
         cycle();
         chk("s_pc", pc_out, 32'(4 * i));
         chk("s_inst", inst_out, inst_of(32'(4 * i)));
      end

      // Stall 6 cycles: FIFO fills to 4 (20,24,28,32), req drops, head held.
      stall = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      chk("st_pc_held", pc_out, 32'd20);
      chk("st_valid", 32'(inst_valid), 32'd1);
      chk("st_req_off", 32'(imem_req), 32'd0);
      stall = 1'b0;
      cycle();
      chk("st_pop1", pc_out, 32'd24);
      chk("st_req_on", 32'(imem_req), 32'd1);
      chk("st_addr", imem_addr, 32'd36);
      for (int k = 2; k <= 5; k++) begin
         cycle();
         chk("st_pop", pc_out, 32'(20 + 4 * k));
         chk("st_pop_v", 32'(inst_valid), 32'd1);
      end

      // Redirect with 2 outstanding (52, 56 held back).
      hold = 1'b1;
      cycle();
      cycle();
      cycle();
      chk("rd_empty", 32'(inst_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      #1;
      chk("rd_noreq", 32'(imem_req), 32'd0);
      cycle();
      redirect_valid = 1'b0;
      hold           = 1'b0;
      #1;
      chk("rd_req", 32'(imem_req), 32'd1);
      chk("rd_addr", imem_addr, 32'h0000_0100);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rd_drop_v", 32'(inst_valid), 32'd0);
      end
      cycle();
      chk("rd_first_v", 32'(inst_valid), 32'd1);
      chk("rd_first_pc", pc_out, 32'h0000_0100);
      chk("rd_first_in", inst_out, inst_of(32'h0000_0100));
      cycle();
      chk("rd_second_pc", pc_out, 32'h0000_0104);

      // Redirect in the same cycle as a live response, with one more granted request.
      hold = 1'b1;
      cycle();
      hold = 1'b0;
      cycle();
      chk("rr_rvalid_setup", 32'(imem_rvalid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2000;
      #1;
      chk("rr_noreq", 32'(imem_req), 32'd0);
      cycle();
      redirect_valid = 1'b0;
      #1;
      chk("rr_addr", imem_addr, 32'h0000_2000);
      chk("rr_v0", 32'(inst_valid), 32'd0);
      cycle();
      chk("rr_v1", 32'(inst_valid), 32'd0);
      cycle();
      chk("rr_pc", pc_out, 32'h0000_2000);
      cycle();
      chk("rr_pc2", pc_out, 32'h0000_2004);

      // Grant withheld: request and address held, buffer drains to NOP.
      imem_gnt = 1'b0;
      #1;
      chk("gl_addr0", imem_addr, 32'h0000_200C);
      cycle();
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("gl_req", 32'(imem_req), 32'd1);
         chk("gl_addr", imem_addr, 32'h0000_200C);
         chk("gl_valid", 32'(inst_valid), 32'd0);
         chk("gl_nop", inst_out, Nop);
         cycle();
      end
      imem_gnt = 1'b1;
      cycle();
      cycle();
      cycle();
      chk("gl_resume", pc_out, 32'h0000_2010);

      // Asynchronous reset mid-burst.
      rst         = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      rq.delete();
      #1;
      chk("ar_req", 32'(imem_req), 32'd0);
      chk("ar_addr", imem_addr, 32'h0);
      chk("ar_valid", 32'(inst_valid), 32'd0);
      chk("ar_inst", inst_out, Nop);
      chk("ar_pc", pc_out, 32'h0);
      cycle();
      rst = 1'b1;
      cycle();
      cycle();
      chk("ar_re_pc0", pc_out, 32'h0);
      chk("ar_re_v", 32'(inst_valid), 32'd1);
      cycle();
      chk("ar_re_pc4", pc_out, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
